// File: rtl/mips_cpu_pkg.sv
// Purpose: shared types for the multicycle MIPS CPU (state encoding, decode codes, ALU ops).
// Latency: n/a, declarations only.
// Backpressure: n/a.
package mips_cpu_pkg;

    // State encoding, also consumed by the control-signal decoder.
    typedef enum logic [2:0] {
        FETCH         = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100,
        HALTED        = 3'b101
    } state_t;

    // Supported final codes: R-type values are func_code, I-type values are opcode.
    typedef enum logic [5:0] {
        FC_JR    = 6'b001000,
        FC_ADDIU = 6'b001001,
        FC_ADDU  = 6'b100001,
        FC_LW    = 6'b100011,
        FC_SW    = 6'b101011
    } final_code_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_PASS_A = 2'b10,
        ALU_NOP    = 2'b11
    } alu_op_t;

    // R-type instructions are identified by func_code, all others by opcode.
    function automatic logic [5:0] get_final_code(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) ? fn : op;
    endfunction

endpackage

// File: rtl/mips_cpu_state_sequencer_if.sv
// Purpose: bundles the sequencer's instruction/bus inputs and status outputs.
// Latency: n/a, wiring only.
// Backpressure: waitrequest from the Avalon bus stalls the sequencer.
// Ports: master = datapath/bus side (drives opcode, func_code, waitrequest, jr_target_zero);
//        slave  = sequencer side (drives state, active, instr_retired, counters, sticky flags).
interface mips_cpu_state_sequencer_if #(
    parameter int CNT_W = 32
);
    import mips_cpu_pkg::*;

    logic [5:0]       opcode;
    logic [5:0]       func_code;
    logic             waitrequest;
    logic             jr_target_zero;
    state_t           state;
    logic             active;
    logic             instr_retired;
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] stall_count;
    logic             illegal_instr;
    logic             bus_timeout;

    modport master (
        output opcode, func_code, waitrequest, jr_target_zero,
        input  state, active, instr_retired, retired_count, stall_count,
               illegal_instr, bus_timeout
    );

    modport slave (
        input  opcode, func_code, waitrequest, jr_target_zero,
        output state, active, instr_retired, retired_count, stall_count,
               illegal_instr, bus_timeout
    );

endinterface

// File: rtl/mips_cpu_wait_timer.sv
// Purpose: counts consecutive waitrequest-high cycles in one memory state, flags timeout.
// Latency: expired is combinational in the MAX_WAIT-th consecutive counted cycle.
// Backpressure: none; clear has priority over count_en. MAX_WAIT=0 never expires.
// Ports: clk, reset_n, count_en (waitrequest high in a memory state), clear (state change), expired.
module mips_cpu_wait_timer #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam int unsigned W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // r_cnt holds the number of earlier consecutive wait cycles, so the
    // MAX_WAIT-th cycle is the one where r_cnt reads MAX_WAIT-1.
    localparam logic [W-1:0] LAST = (MAX_WAIT == 0) ? '0 : W'(MAX_WAIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (count_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = (MAX_WAIT != 0) && count_en && (r_cnt == LAST);

endmodule

// File: rtl/mips_cpu_state_sequencer.sv
// Purpose: multicycle state register/next-state logic with halt causes and retire/stall counters.
// Latency: zero-wait ALU 4, LW 5, SW 4, JR 3 cycles; instr_retired combinational in last cycle.
// Backpressure: waitrequest holds FETCH/MEMORY_ACCESS; MAX_WAIT consecutive stalls halt the CPU.
// Ports: clk, reset_n (async active-low), bus (slave modport: decode inputs, state and status).
module mips_cpu_state_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int          CNT_W    = 32
) (
    input logic                        clk,
    input logic                        reset_n,
    mips_cpu_state_sequencer_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_stall;
    logic             r_illegal;
    logic             r_timeout;

    logic       w_retire;
    logic       w_stall;
    logic       w_set_illegal;
    logic       w_set_timeout;
    logic       w_expired;
    logic       w_rtype;
    logic [5:0] w_final;

    assign w_final = get_final_code(bus.opcode, bus.func_code);
    assign w_rtype = (bus.opcode == 6'd0);
    // Stall is independent of the timer result, so the timer enable has no loop.
    assign w_stall = bus.waitrequest && ((r_state == FETCH) || (r_state == MEMORY_ACCESS));

    mips_cpu_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (w_stall),
        .clear    (w_next != r_state),
        .expired  (w_expired)
    );

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            FETCH: begin
                if (!bus.waitrequest) begin
                    w_next = DECODE;
                end else if (w_expired) begin
                    w_next        = HALTED;
                    w_set_timeout = 1'b1;
                end
            end
            DECODE: w_next = EXECUTE;
            EXECUTE: begin
                // R-type codes only count with opcode 0, I-type codes only with a nonzero opcode.
                if ((w_rtype && w_final == FC_ADDU) || (!w_rtype && w_final == FC_ADDIU)) begin
                    w_next = WRITE_BACK;
                end else if (!w_rtype && (w_final == FC_LW || w_final == FC_SW)) begin
                    w_next = MEMORY_ACCESS;
                end else if (w_rtype && w_final == FC_JR) begin
                    w_retire = 1'b1;
                    w_next   = bus.jr_target_zero ? HALTED : FETCH;
                end else begin
                    w_next        = HALTED;
                    w_set_illegal = 1'b1;
                end
            end
            MEMORY_ACCESS: begin
                if (!bus.waitrequest) begin
                    if (bus.opcode == FC_LW) begin
                        w_next = WRITE_BACK;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = FETCH;
                    end
                end else if (w_expired) begin
                    w_next        = HALTED;
                    w_set_timeout = 1'b1;
                end
            end
            WRITE_BACK: begin
                w_retire = 1'b1;
                w_next   = FETCH;
            end
            HALTED:  w_next = HALTED;
            default: w_next = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= FETCH;
            r_retired <= '0;
            r_stall   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
            if (w_stall)  r_stall   <= r_stall + CNT_W'(1);
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
        end
    end

    assign bus.state         = r_state;
    assign bus.active        = (r_state != HALTED);
    assign bus.instr_retired = w_retire;
    assign bus.retired_count = r_retired;
    assign bus.stall_count   = r_stall;
    assign bus.illegal_instr = r_illegal;
    assign bus.bus_timeout   = r_timeout;

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Purpose: self-checking bench for mips_cpu_state_sequencer (vector table + scoreboard + corner sequences).
// Latency: n/a.
// Backpressure: waitrequest is driven per state from each vector's wait counts.
module tb_mips_cpu_state_sequencer;
    import mips_cpu_pkg::*;

    localparam int CNT_W = 32;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mips_cpu_state_sequencer_if #(.CNT_W(CNT_W)) sif ();

    mips_cpu_state_sequencer #(.MAX_WAIT(16), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       jrz;
        logic [7:0] fw;       // waitrequest-high cycles in FETCH
        logic [7:0] mw;       // waitrequest-high cycles in MEMORY_ACCESS
        logic [7:0] e_cyc;    // clock edges until back in FETCH or HALTED
        logic [1:0] e_pulses;
        logic [2:0] e_state;
        logic [7:0] e_ret;
        logic [7:0] e_stall;
        logic       e_ill;
        logic       e_to;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    vec_t exp_q [$];

    task automatic chk(input string nm, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        sif.opcode         = 6'd0;
        sif.func_code      = 6'd0;
        sif.waitrequest    = 1'b0;
        sif.jr_target_zero = 1'b0;
        reset_n            = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one instruction starting at a negedge in FETCH; returns at a negedge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic jrz,
                             input int fw, input int mw, output int cyc, output int pulses);
        int  fcnt;
        int  mcnt;
        bit  left;
        fcnt = 0; mcnt = 0; cyc = 0; pulses = 0; left = 0;
        sif.opcode         = op;
        sif.func_code      = fn;
        sif.jr_target_zero = jrz;
        do begin
            if (sif.state == FETCH) begin
                sif.waitrequest = (fcnt < fw);
                fcnt++;
            end else if (sif.state == MEMORY_ACCESS) begin
                sif.waitrequest = (mcnt < mw);
                mcnt++;
            end else begin
                sif.waitrequest = 1'b0;
            end
            #1;
            if (sif.instr_retired) pulses++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (sif.state != FETCH) left = 1;
        end while (!(sif.state == HALTED || (left && sif.state == FETCH)) && cyc < 200);
        sif.waitrequest = 1'b0;
    endtask

    initial begin
        int   cyc;
        int   pulses;
        vec_t e;

        checks = 0;
        errors = 0;
        reset_n = 1'b0;

        //            op         fn         jrz  fw      mw      cyc    pul   state  ret    stall  ill   to
        vecs[0]  = '{6'b001001, 6'd0,      1'b0, 8'd0,   8'd0,   8'd4,  2'd1, 3'd0, 8'd1,  8'd0,  1'b0, 1'b0}; // ADDIU
        vecs[1]  = '{6'd0,      6'b100001, 1'b0, 8'd2,   8'd0,   8'd6,  2'd1, 3'd0, 8'd1,  8'd2,  1'b0, 1'b0}; // ADDU, fetch waits
        vecs[2]  = '{6'b100011, 6'd0,      1'b0, 8'd0,   8'd3,   8'd8,  2'd1, 3'd0, 8'd1,  8'd3,  1'b0, 1'b0}; // LW, 3 mem waits
        vecs[3]  = '{6'b101011, 6'd0,      1'b0, 8'd1,   8'd2,   8'd7,  2'd1, 3'd0, 8'd1,  8'd3,  1'b0, 1'b0}; // SW
        vecs[4]  = '{6'd0,      6'b001000, 1'b0, 8'd0,   8'd0,   8'd3,  2'd1, 3'd0, 8'd1,  8'd0,  1'b0, 1'b0}; // JR nonzero
        vecs[5]  = '{6'd0,      6'b001000, 1'b1, 8'd0,   8'd0,   8'd3,  2'd1, 3'd5, 8'd1,  8'd0,  1'b0, 1'b0}; // JR to 0
        vecs[6]  = '{6'b000010, 6'd0,      1'b0, 8'd0,   8'd0,   8'd3,  2'd0, 3'd5, 8'd0,  8'd0,  1'b1, 1'b0}; // J illegal
        vecs[7]  = '{6'd0,      6'b100000, 1'b0, 8'd0,   8'd0,   8'd3,  2'd0, 3'd5, 8'd0,  8'd0,  1'b1, 1'b0}; // ADD illegal
        vecs[8]  = '{6'b001001, 6'd0,      1'b0, 8'd100, 8'd0,   8'd16, 2'd0, 3'd5, 8'd0,  8'd16, 1'b0, 1'b1}; // fetch timeout
        vecs[9]  = '{6'b100011, 6'd0,      1'b0, 8'd0,   8'd100, 8'd19, 2'd0, 3'd5, 8'd0,  8'd16, 1'b0, 1'b1}; // mem timeout
        vecs[10] = '{6'b100011, 6'd0,      1'b0, 8'd0,   8'd15,  8'd20, 2'd1, 3'd0, 8'd1,  8'd15, 1'b0, 1'b0}; // 15 waits, no timeout
        vecs[11] = '{6'b001001, 6'd0,      1'b0, 8'd15,  8'd0,   8'd19, 2'd1, 3'd0, 8'd1,  8'd15, 1'b0, 1'b0}; // 15 fetch waits

        // Reset state.
        do_reset();
        chk("rst_state",   0, sif.state, FETCH);
        chk("rst_active",  0, sif.active, 1);
        chk("rst_retire",  0, sif.instr_retired, 0);
        chk("rst_retired", 0, sif.retired_count, 0);
        chk("rst_stall",   0, sif.stall_count, 0);
        chk("rst_illegal", 0, sif.illegal_instr, 0);
        chk("rst_timeout", 0, sif.bus_timeout, 0);

        // Table: each vector from a fresh reset; expected record queued at drive time.
        for (int i = 0; i < NV; i++) begin
            do_reset();
            exp_q.push_back(vecs[i]);
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].jrz, int'(vecs[i].fw), int'(vecs[i].mw),
                      cyc, pulses);
            e = exp_q.pop_front();
            chk("cycles",  i, cyc, e.e_cyc);
            chk("pulses",  i, pulses, e.e_pulses);
            chk("state",   i, sif.state, e.e_state);
            chk("active",  i, sif.active, (e.e_state != 3'd5));
            chk("retired", i, sif.retired_count, e.e_ret);
            chk("stall",   i, sif.stall_count, e.e_stall);
            chk("illegal", i, sif.illegal_instr, e.e_ill);
            chk("timeout", i, sif.bus_timeout, e.e_to);
        end

        // SW then JR to zero back to back, then HALTED must absorb a toggling waitrequest.
        do_reset();
        run_instr(6'b101011, 6'd0, 1'b0, 0, 0, cyc, pulses);
        chk("sw_cycles", 0, cyc, 4);
        chk("sw_retired", 0, sif.retired_count, 1);
        run_instr(6'd0, 6'b001000, 1'b1, 0, 0, cyc, pulses);
        chk("jr_cycles", 0, cyc, 3);
        chk("jr_state", 0, sif.state, HALTED);
        chk("jr_active", 0, sif.active, 0);
        chk("jr_retired", 0, sif.retired_count, 2);
        for (int k = 0; k < 20; k++) begin
            sif.waitrequest = k[0];
            #1;
            chk("halt_retire", k, sif.instr_retired, 0);
            @(posedge clk);
            @(negedge clk);
            chk("halt_state", k, sif.state, HALTED);
        end
        chk("halt_retired", 0, sif.retired_count, 2);
        chk("halt_stall", 0, sif.stall_count, 0);
        chk("halt_flags", 0, {sif.illegal_instr, sif.bus_timeout}, 0);

        // Asynchronous reset while stalled in MEMORY_ACCESS.
        do_reset();
        run_instr(6'b001001, 6'd0, 1'b0, 0, 0, cyc, pulses);
        sif.opcode = 6'b100011;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        sif.waitrequest = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_state", 0, sif.state, MEMORY_ACCESS);
        chk("mid_stall", 0, sif.stall_count, 3);
        chk("mid_retired", 0, sif.retired_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state",   0, sif.state, FETCH);
        chk("arst_active",  0, sif.active, 1);
        chk("arst_retired", 0, sif.retired_count, 0);
        chk("arst_stall",   0, sif.stall_count, 0);
        chk("arst_flags",   0, {sif.illegal_instr, sif.bus_timeout}, 0);
        @(negedge clk);
        sif.waitrequest = 1'b0;
        reset_n = 1'b1;
        // Wait counter must also be clear: 15 fresh fetch waits must not time out.
        run_instr(6'b001001, 6'd0, 1'b0, 15, 0, cyc, pulses);
        chk("post_cycles", 0, cyc, 19);
        chk("post_timeout", 0, sif.bus_timeout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
